otter_pipe_ctrl: RTL and testbench
==================================

Name: otter_pipe_ctrl

Overview:
Parametrised pipeline control unit for the 5-stage pipelined OTTER (IF, DE, EX, MEM, WB).
- Centralises per-stage valid tracking, stall generation, branch flush and trap flush.
- Handles load-use interlock with configurable bubble count, variable-latency data-memory stalls with timeout detection, and EX-operand forwarding selects.
- Includes a saturating stall-cycle counter.
- Sits beside the datapath; drives every pipeline-register enable and the forwarding muxes.

Parameters:
REG_ADDR_W, 5, register-address width.
LOAD_USE_BUBBLES, 1, bubbles inserted on load-use (legal 1..3).
MAX_MEM_WAIT, 15, consecutive mem_busy cycles before mem_timeout sets.
CNT_W, 32, stall-cycle counter width.

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
id_rs1_addr / id_rs2_addr  in  REG_ADDR_W  DE-stage source registers
id_rs1_used / id_rs2_used  in  1  DE instruction reads rs1/rs2
ex_rs1_addr / ex_rs2_addr  in  REG_ADDR_W  EX-stage source registers
ex_rd, mem_rd, wb_rd  in  REG_ADDR_W  destination register per stage
ex_rd_we, mem_rd_we, wb_rd_we  in  1  stage writes rd
ex_is_load, mem_is_load  in  1  stage holds a load
branch_taken  in  1  EX redirects PC (raw; qualified internally by v_ex)
mem_busy  in  1  data memory not ready for the MEM-stage access
flush_all  in  1  trap/interrupt redirect request (1-cycle pulse)
stall_pc, stall_if, stall_de, stall_ex, stall_mem  out  1  hold respective register
v_de, v_ex, v_mem, v_wb  out  1  stage-register valid bits
fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 MEM aluRes, 10 WB data
flush_ack  out  1  pulse: pending flush applied this cycle
mem_timeout  out  1  sticky timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
Reset
- RESET (sync) clears v_*, bubble counter, wait counter, flush_pending, mem_timeout and stall_cycles.
- While RESET is asserted, all stall outputs are 0.
- First rising edge after release sets v_de=1.

Combinational terms
- mem_stall = v_mem & mem_busy.
- br = v_ex & branch_taken.
- lu_hit = v_de & v_ex & ex_is_load & ex_rd_we & ex_rd!=0 & ((id_rs1_used & id_rs1_addr==ex_rd) | (id_rs2_used & id_rs2_addr==ex_rd)).
- load_use = (lu_hit | bub_cnt!=0) & !br.

Priority: RESET > mem_stall > flush (pending or new) > br > load_use.

mem_stall
- All five stalls = 1; v_de..v_mem hold; v_wb<=0.
- wait_cnt increments; mem_timeout<=1 when wait_cnt reaches MAX_MEM_WAIT-1 while still busy.
- wait_cnt clears on the first non-busy cycle.

Flush
- flush_all arriving during mem_stall sets flush_pending.
- A flush (flush_all or flush_pending) without mem_stall: v_de,v_ex,v_mem,v_wb<=0; flush_pending<=0; bub_cnt<=0; flush_ack=1 that cycle; stalls 0.

Branch
- br without flush/mem_stall: v_de<=0, v_ex<=0, v_mem<=v_ex, v_wb<=v_mem; no stall.
- br overrides a simultaneous load_use.

Load-use
- stall_pc, stall_if, stall_de = 1; v_de holds; v_ex<=0 (bubble); v_mem<=v_ex; v_wb<=v_mem.
- On lu_hit with bub_cnt==0: bub_cnt<=LOAD_USE_BUBBLES-1. Otherwise bub_cnt decrements.

Normal operation: v_de<=1, v_ex<=v_de, v_mem<=v_ex, v_wb<=v_mem.

Forwarding (combinational, same rule for a/b)
- 01 if v_mem & mem_rd_we & !mem_is_load & mem_rd!=0 & mem_rd==ex_rsX.
- Else 10 if v_wb & wb_rd_we & wb_rd!=0 & wb_rd==ex_rsX.
- Else 00.
- MEM has priority over WB.

stall_cycles: +1 each cycle stall_if=1, saturating at all-ones.

Decomposition:
- otter_pkg: opcode_t, fwd_sel_t enum (FWD_RF=0, FWD_MEM=1, FWD_WB=2), stage-valid struct.
- Sub-module otter_fwd_unit: combinational forwarding compare, instantiated once per operand.

Test Plan:
1. RESET high 2 cycles then low -> all v_*=0, stalls 0, stall_cycles=0 during reset; v_de=1 at edge 1, v_ex=1 at edge 2, v_wb=1 at edge 4.
2. ex_is_load, ex_rd=5, id_rs1_addr=5 used -> stall_pc/if/de=1 for 1 cycle, v_ex=0 next, stall_cycles=1. Rerun with LOAD_USE_BUBBLES=3 -> 3 stall cycles, then resume.
3. ex_rs1=3, mem_rd=3/we, wb_rd=3/we -> fwd_a_sel=01. Drop v_mem -> 10. mem_is_load=1 -> 10. rd=0 -> 00.
4. branch_taken with lu_hit same cycle -> no stall, v_de=0 and v_ex=0 next, v_mem=1.
5. mem_busy 3 cycles -> all stalls 1 for 3 cycles, v_wb=0, no timeout. MAX_MEM_WAIT=4 with 5 busy cycles -> mem_timeout=1 after 4th cycle, stays until RESET.
6. flush_all pulsed in 2nd of 3 mem_busy cycles -> flush_ack=1 on first non-busy cycle, all v_*=0 next; RESET mid-stall -> all state cleared.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipeline control slice.
// Contents: opcode_t (RV32I major opcodes), fwd_sel_t (EX operand source),
// stage_valid_t (DE/EX/MEM/WB valid bits) and a stage-advance helper.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic de;
    logic ex;
    logic mem;
    logic wb;
  } stage_valid_t;

  // Shift every valid bit one stage down the pipe, filling DE with 'fill'.
  function automatic stage_valid_t advance(input stage_valid_t v, input logic fill);
    stage_valid_t r;
    r.de  = fill;
    r.ex  = v.de;
    r.mem = v.ex;
    r.wb  = v.mem;
    return r;
  endfunction

endpackage

// File: rtl/otter_fwd_unit.sv
// EX-operand forwarding select for one source operand.
// Ports: ex_rs (EX source reg), v_mem/mem_rd_we/mem_is_load/mem_rd (MEM
// producer), v_wb/wb_rd_we/wb_rd (WB producer), sel (RF, MEM aluRes or WB data).
module otter_fwd_unit
  import otter_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic                  v_mem,
  input  logic                  mem_rd_we,
  input  logic                  mem_is_load,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  v_wb,
  input  logic                  wb_rd_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output fwd_sel_t              sel
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet, so only ALU results forward from MEM.
  assign mem_hit = v_mem && mem_rd_we && !mem_is_load && (mem_rd != '0) && (mem_rd == ex_rs);
  assign wb_hit  = v_wb && wb_rd_we && (wb_rd != '0) && (wb_rd == ex_rs);

  // MEM is the younger producer and wins over WB.
  always_comb begin
    sel = FWD_RF;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// Pipeline control for the 5-stage OTTER: stage valids, stalls, branch/trap
// flush, load-use interlock, data-memory wait timeout, forwarding selects and
// a saturating stall-cycle counter.
// Ports: CLK/RESET (sync, active-high); DE/EX/MEM/WB register info in;
// branch_taken, mem_busy, flush_all events in; stall_* (combinational),
// v_* (registered), fwd_a_sel/fwd_b_sel, flush_ack, mem_timeout, stall_cycles out.
module otter_pipe_ctrl
  import otter_pkg::*;
#(
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned MAX_MEM_WAIT     = 15,
  parameter int unsigned CNT_W            = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  ex_rd_we,
  input  logic                  mem_rd_we,
  input  logic                  wb_rd_we,
  input  logic                  ex_is_load,
  input  logic                  mem_is_load,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  input  logic                  flush_all,
  output logic                  stall_pc,
  output logic                  stall_if,
  output logic                  stall_de,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  v_de,
  output logic                  v_ex,
  output logic                  v_mem,
  output logic                  v_wb,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  flush_ack,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned BUB_W  = 2;
  localparam int unsigned WAIT_W = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [BUB_W-1:0]  BUB_RELOAD = BUB_W'(LOAD_USE_BUBBLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MAX_MEM_WAIT - 1);

  stage_valid_t      vld, vld_nxt;
  logic [BUB_W-1:0]  bub_cnt, bub_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              flush_pending, pend_nxt;
  logic              tmo_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic     mem_stall, br, lu_hit, load_use, flush_req;
  logic     stall_front, stall_back;
  fwd_sel_t fwd_a, fwd_b;

  // Hazard terms.
  assign mem_stall = vld.mem & mem_busy;
  assign br        = vld.ex & branch_taken;
  assign lu_hit    = vld.de & vld.ex & ex_is_load & ex_rd_we & (ex_rd != '0) &
                     ((id_rs1_used & (id_rs1_addr == ex_rd)) |
                      (id_rs2_used & (id_rs2_addr == ex_rd)));
  assign load_use  = (lu_hit | (bub_cnt != '0)) & ~br;
  assign flush_req = flush_all | flush_pending;

  // Next-state and stall decode, priority RESET > mem_stall > flush > br > load_use.
  always_comb begin
    vld_nxt     = vld;
    bub_nxt     = bub_cnt;
    wait_nxt    = '0;
    pend_nxt    = flush_pending;
    tmo_nxt     = mem_timeout;
    stall_front = 1'b0;
    stall_back  = 1'b0;
    flush_ack   = 1'b0;

    if (RESET) begin
      vld_nxt  = '0;
      bub_nxt  = '0;
      pend_nxt = 1'b0;
      tmo_nxt  = 1'b0;
    end else if (mem_stall) begin
      stall_front = 1'b1;
      stall_back  = 1'b1;
      vld_nxt.wb  = 1'b0;
      // wait_cnt saturates at its last value so the flag stays meaningful.
      if (wait_cnt == WAIT_LAST) begin
        tmo_nxt  = 1'b1;
        wait_nxt = wait_cnt;
      end else begin
        wait_nxt = wait_cnt + WAIT_W'(1);
      end
      if (flush_all) begin
        pend_nxt = 1'b1;
      end
    end else if (flush_req) begin
      vld_nxt   = '0;
      bub_nxt   = '0;
      pend_nxt  = 1'b0;
      flush_ack = 1'b1;
    end else if (br) begin
      // The stalled DE instruction is squashed, so pending bubbles go with it.
      vld_nxt    = advance(vld, 1'b0);
      vld_nxt.ex = 1'b0;
      bub_nxt    = '0;
    end else if (load_use) begin
      stall_front = 1'b1;
      vld_nxt     = advance(vld, 1'b0);
      vld_nxt.de  = vld.de;
      vld_nxt.ex  = 1'b0;
      if (lu_hit && (bub_cnt == '0)) begin
        bub_nxt = BUB_RELOAD;
      end else begin
        bub_nxt = bub_cnt - BUB_W'(1);
      end
    end else begin
      vld_nxt = advance(vld, 1'b1);
    end

    cnt_nxt = stall_cycles;
    if (RESET) begin
      cnt_nxt = '0;
    end else if (stall_front && (stall_cycles != '1)) begin
      cnt_nxt = stall_cycles + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    vld           <= vld_nxt;
    bub_cnt       <= bub_nxt;
    wait_cnt      <= RESET ? '0 : wait_nxt;
    flush_pending <= pend_nxt;
    mem_timeout   <= tmo_nxt;
    stall_cycles  <= cnt_nxt;
  end

  assign stall_pc  = stall_front;
  assign stall_if  = stall_front;
  assign stall_de  = stall_front;
  assign stall_ex  = stall_back;
  assign stall_mem = stall_back;

  assign v_de  = vld.de;
  assign v_ex  = vld.ex;
  assign v_mem = vld.mem;
  assign v_wb  = vld.wb;

  otter_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs       (ex_rs1_addr),
    .v_mem       (vld.mem),
    .mem_rd_we   (mem_rd_we),
    .mem_is_load (mem_is_load),
    .mem_rd      (mem_rd),
    .v_wb        (vld.wb),
    .wb_rd_we    (wb_rd_we),
    .wb_rd       (wb_rd),
    .sel         (fwd_a)
  );

  otter_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs       (ex_rs2_addr),
    .v_mem       (vld.mem),
    .mem_rd_we   (mem_rd_we),
    .mem_is_load (mem_is_load),
    .mem_rd      (mem_rd),
    .v_wb        (vld.wb),
    .wb_rd_we    (wb_rd_we),
    .wb_rd       (wb_rd),
    .sel         (fwd_b)
  );

  assign fwd_a_sel = fwd_a;
  assign fwd_b_sel = fwd_b;

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Scoreboard bench: two DUTs (default parameters and LOAD_USE_BUBBLES=3,
// MAX_MEM_WAIT=4, CNT_W=4) share one stimulus stream; a reference model per
// instance predicts each cycle's outputs, a negedge monitor compares them.
module tb_otter_pipe_ctrl;

  typedef struct {
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_rs1_used, id_rs2_used, ex_we, mem_we, wb_we, ex_load, mem_load;
    logic br, busy, flush, rst;
  } stim_t;

  typedef struct {
    logic [4:0] stl;   // {pc, if, de, ex, mem}
    logic [3:0] v;     // {de, ex, mem, wb}
    logic [1:0] fa, fb;
    logic       ack, tmo;
    longint     cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd, mem_rd, wb_rd;
  logic id_rs1_used, id_rs2_used, ex_rd_we, mem_rd_we, wb_rd_we, ex_is_load, mem_is_load;
  logic branch_taken, mem_busy, flush_all;

  logic [1:0] stall_pc, stall_if, stall_de, stall_ex, stall_mem;
  logic [1:0] v_de, v_ex, v_mem, v_wb, flush_ack, mem_timeout;
  logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
  logic [31:0] cnt0;
  logic [3:0]  cnt1;

  always #5 CLK = ~CLK;

  otter_pipe_ctrl dut0 (
    .CLK(CLK), .RESET(RESET),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rd_we(ex_rd_we), .mem_rd_we(mem_rd_we), .wb_rd_we(wb_rd_we),
    .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .flush_all(flush_all),
    .stall_pc(stall_pc[0]), .stall_if(stall_if[0]), .stall_de(stall_de[0]),
    .stall_ex(stall_ex[0]), .stall_mem(stall_mem[0]),
    .v_de(v_de[0]), .v_ex(v_ex[0]), .v_mem(v_mem[0]), .v_wb(v_wb[0]),
    .fwd_a_sel(fwd_a0), .fwd_b_sel(fwd_b0),
    .flush_ack(flush_ack[0]), .mem_timeout(mem_timeout[0]), .stall_cycles(cnt0)
  );

  otter_pipe_ctrl #(.REG_ADDR_W(5), .LOAD_USE_BUBBLES(3), .MAX_MEM_WAIT(4), .CNT_W(4)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rd_we(ex_rd_we), .mem_rd_we(mem_rd_we), .wb_rd_we(wb_rd_we),
    .ex_is_load(ex_is_load), .mem_is_load(mem_is_load),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .flush_all(flush_all),
    .stall_pc(stall_pc[1]), .stall_if(stall_if[1]), .stall_de(stall_de[1]),
    .stall_ex(stall_ex[1]), .stall_mem(stall_mem[1]),
    .v_de(v_de[1]), .v_ex(v_ex[1]), .v_mem(v_mem[1]), .v_wb(v_wb[1]),
    .fwd_a_sel(fwd_a1), .fwd_b_sel(fwd_b1),
    .flush_ack(flush_ack[1]), .mem_timeout(mem_timeout[1]), .stall_cycles(cnt1)
  );

  // Reference model state per instance: occupancy of DE, EX, MEM, WB (index 0..3).
  int     lub[2]     = '{1, 3};
  int     maxw[2]    = '{15, 4};
  longint cmax[2]    = '{64'hFFFF_FFFF, 64'd15};
  bit     occ[2][4];
  int     bubbles_left[2];
  int     busy_run[2];
  bit     pend[2];
  bit     tmo[2];
  longint cnt[2];

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [1:0] fwd_model(input int i, input logic [4:0] rs, input stim_t s);
    if (occ[i][2] && s.mem_we && !s.mem_load && s.mem_rd != 0 && s.mem_rd == rs) return 2'b01;
    if (occ[i][3] && s.wb_we && s.wb_rd != 0 && s.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear(input int i);
    for (int k = 0; k < 4; k++) occ[i][k] = 1'b0;
    bubbles_left[i] = 0;
    busy_run[i] = 0;
    pend[i] = 1'b0;
    tmo[i] = 1'b0;
    cnt[i] = 0;
  endtask

  // Predict this cycle's outputs, then advance the model across the clock edge.
  task automatic model_cycle(input int i, input stim_t s, output exp_t e);
    bit ms, br, hit, lu, front;
    ms  = occ[i][2] && s.busy;
    br  = occ[i][1] && s.br;
    hit = occ[i][0] && occ[i][1] && s.ex_load && s.ex_we && s.ex_rd != 0 &&
          ((s.id_rs1_used && s.id_rs1 == s.ex_rd) || (s.id_rs2_used && s.id_rs2 == s.ex_rd));
    lu  = (hit || bubbles_left[i] > 0) && !br;
    e.v   = {occ[i][0], occ[i][1], occ[i][2], occ[i][3]};
    e.fa  = fwd_model(i, s.ex_rs1, s);
    e.fb  = fwd_model(i, s.ex_rs2, s);
    e.tmo = tmo[i];
    e.cnt = cnt[i];
    e.stl = 5'b0;
    e.ack = 1'b0;
    front = 1'b0;
    if (s.rst) begin
      model_clear(i);
      return;
    end
    if (ms) begin
      e.stl = 5'b11111;
      front = 1'b1;
      occ[i][3] = 1'b0;
      busy_run[i]++;
      if (busy_run[i] >= maxw[i]) tmo[i] = 1'b1;
      if (s.flush) pend[i] = 1'b1;
    end else begin
      busy_run[i] = 0;
      if (s.flush || pend[i]) begin
        e.ack = 1'b1;
        for (int k = 0; k < 4; k++) occ[i][k] = 1'b0;
        pend[i] = 1'b0;
        bubbles_left[i] = 0;
      end else if (br) begin
        occ[i][3] = occ[i][2];
        occ[i][2] = occ[i][1];
        occ[i][1] = 1'b0;
        occ[i][0] = 1'b0;
        bubbles_left[i] = 0;
      end else if (lu) begin
        e.stl = 5'b11100;
        front = 1'b1;
        occ[i][3] = occ[i][2];
        occ[i][2] = occ[i][1];
        occ[i][1] = 1'b0;
        if (bubbles_left[i] == 0) bubbles_left[i] = lub[i] - 1;
        else bubbles_left[i]--;
      end else begin
        occ[i][3] = occ[i][2];
        occ[i][2] = occ[i][1];
        occ[i][1] = occ[i][0];
        occ[i][0] = 1'b1;
      end
    end
    if (front && cnt[i] < cmax[i]) cnt[i]++;
  endtask

  function automatic exp_t actual(input int i);
    exp_t a;
    a.stl = {stall_pc[i], stall_if[i], stall_de[i], stall_ex[i], stall_mem[i]};
    a.v   = {v_de[i], v_ex[i], v_mem[i], v_wb[i]};
    a.fa  = (i == 0) ? fwd_a0 : fwd_a1;
    a.fb  = (i == 0) ? fwd_b0 : fwd_b1;
    a.ack = flush_ack[i];
    a.tmo = mem_timeout[i];
    a.cnt = (i == 0) ? longint'(cnt0) : longint'(cnt1);
    return a;
  endfunction

  task automatic check(input string nm, input int i, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL cyc=%0d dut%0d %s: got %0h expected %0h", cyc, i, nm, act, exp);
    end
  endtask

  task automatic compare(input int i, input exp_t e);
    exp_t a;
    a = actual(i);
    check("stalls", i, longint'(a.stl), longint'(e.stl));
    check("valids", i, longint'(a.v), longint'(e.v));
    check("fwd_a_sel", i, longint'(a.fa), longint'(e.fa));
    check("fwd_b_sel", i, longint'(a.fb), longint'(e.fb));
    check("flush_ack", i, longint'(a.ack), longint'(e.ack));
    check("mem_timeout", i, longint'(a.tmo), longint'(e.tmo));
    check("stall_cycles", i, a.cnt, e.cnt);
  endtask

  // Monitor: every cycle both DUTs present a full output set.
  always @(negedge CLK) begin
    if (q0.size() != 0) compare(0, q0.pop_front());
    if (q1.size() != 0) compare(1, q1.pop_front());
  end

  task automatic step(input stim_t s);
    exp_t e0, e1;
    id_rs1_addr = s.id_rs1; id_rs2_addr = s.id_rs2;
    id_rs1_used = s.id_rs1_used; id_rs2_used = s.id_rs2_used;
    ex_rs1_addr = s.ex_rs1; ex_rs2_addr = s.ex_rs2;
    ex_rd = s.ex_rd; mem_rd = s.mem_rd; wb_rd = s.wb_rd;
    ex_rd_we = s.ex_we; mem_rd_we = s.mem_we; wb_rd_we = s.wb_we;
    ex_is_load = s.ex_load; mem_is_load = s.mem_load;
    branch_taken = s.br; mem_busy = s.busy; flush_all = s.flush; RESET = s.rst;
    model_cycle(0, s, e0);
    model_cycle(1, s, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge CLK);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) step(idle());
  endtask

  task automatic busy_n(input int n, input int flush_at);
    stim_t s;
    for (int k = 0; k < n; k++) begin
      s = idle();
      s.busy = 1'b1;
      s.flush = (k == flush_at);
      step(s);
    end
  endtask

  initial begin
    stim_t s, lu;
    RESET = 1'b1;
    branch_taken = 1'b0; mem_busy = 1'b0; flush_all = 1'b0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_rd_we = 1'b0; mem_rd_we = 1'b0; wb_rd_we = 1'b0;
    ex_is_load = 1'b0; mem_is_load = 1'b0;
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rs1_addr = '0; ex_rs2_addr = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    model_clear(0);
    model_clear(1);
    @(posedge CLK);
    #1;

    // Reset held a second cycle, then the pipe fills one stage per edge.
    s = idle(); s.rst = 1'b1;
    step(s);
    idle_n(5);

    // Load-use on rs1 = x5.
    lu = idle();
    lu.ex_load = 1'b1; lu.ex_we = 1'b1; lu.ex_rd = 5'd5; lu.id_rs1 = 5'd5; lu.id_rs1_used = 1'b1;
    step(lu);
    idle_n(5);

    // Forwarding: MEM, WB on MEM load, zero register, operand b.
    s = idle();
    s.ex_rs1 = 5'd3; s.ex_rs2 = 5'd4;
    s.mem_rd = 5'd3; s.mem_we = 1'b1; s.wb_rd = 5'd3; s.wb_we = 1'b1;
    step(s);
    s.mem_load = 1'b1; step(s);
    s.mem_load = 1'b0; s.mem_we = 1'b0; step(s);
    s.ex_rs1 = 5'd0; s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.mem_we = 1'b1; step(s);
    s.ex_rs2 = 5'd4; s.mem_rd = 5'd4; s.wb_rd = 5'd4; step(s);

    // Branch with a simultaneous load-use hit.
    lu.br = 1'b1;
    step(lu);
    idle_n(4);

    // Short memory wait, then a wait long enough to time out the second DUT.
    busy_n(3, -1);
    idle_n(4);
    busy_n(5, -1);
    idle_n(4);

    // Flush arriving mid-wait is held until memory is ready.
    busy_n(3, 1);
    idle_n(4);

    // Reset during a memory wait.
    busy_n(2, -1);
    s = idle(); s.busy = 1'b1; s.rst = 1'b1;
    step(s);
    idle_n(5);

    // Randomised traffic over a small register space so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.id_rs1 = 5'($urandom_range(0, 3));  s.id_rs2 = 5'($urandom_range(0, 3));
      s.ex_rs1 = 5'($urandom_range(0, 3));  s.ex_rs2 = 5'($urandom_range(0, 3));
      s.ex_rd  = 5'($urandom_range(0, 3));  s.mem_rd = 5'($urandom_range(0, 3));
      s.wb_rd  = 5'($urandom_range(0, 3));
      s.id_rs1_used = 1'($urandom_range(0, 1)); s.id_rs2_used = 1'($urandom_range(0, 1));
      s.ex_we = 1'($urandom_range(0, 1)); s.mem_we = 1'($urandom_range(0, 1));
      s.wb_we = 1'($urandom_range(0, 1));
      s.ex_load  = 1'($urandom_range(0, 1));
      s.mem_load = ($urandom_range(0, 3) == 0);
      s.br    = ($urandom_range(0, 7) == 0);
      s.busy  = ($urandom_range(0, 2) == 0);
      s.flush = ($urandom_range(0, 31) == 0);
      s.rst   = ($urandom_range(0, 63) == 0);
      step(s);
    end
    idle_n(2);

    @(negedge CLK);
    #1;
    n_vec++;
    if (q0.size() + q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
